dbus_drive_ctl: RTL and testbench
=================================

DBUS_DRIVE_CTL -- requirements
Module: dbus_drive_ctl

Interface
REQ-001 Parameter: WIDTH, default 64, dbus width in bits (legal 1..128).
REQ-002 Parameter: NSRC, default 4, number of requesting sources (legal 1..8).
REQ-003 Parameter: TURN, default 1, idle turnaround cycles after a burst before the next arbitration (legal 0..7).
REQ-004 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: src_req  in  NSRC  per-source request/beat-valid.
REQ-007 Port: src_data  in  NSRC*WIDTH  per-source beat data; source i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port: src_last  in  NSRC  marks the final beat of a burst.
REQ-009 Port: ext_busy  in  1  external agent owns dbus; blocks new grants.
REQ-010 Port: src_gnt  out  NSRC  registered one-hot grant.
REQ-011 Port: src_ack  out  NSRC  beat accepted this cycle (combinational).
REQ-012 Port: dbus_oe  out  1  registered tri-state enable, also observable.
REQ-013 Port: dbus_data  out (tri-state)  WIDTH  driven from the output data register when dbus_oe=1, high-impedance otherwise.

Function
REQ-014 FSM states: IDLE, DRIVE, LAST, TURN; exactly one state active.
REQ-015 IDLE: if ext_busy=0 and any src_req=1, pick a winner by round-robin starting at (prev_owner+1) mod NSRC; next cycle state=DRIVE, src_gnt=one-hot(winner), prev_owner=winner.
REQ-016 IDLE with ext_busy=1 or no request: stay in IDLE, src_gnt=0.
REQ-017 DRIVE: src_ack[g]=src_req[g] for granted g; all other src_ack bits are 0; src_ack=0 in every other state.
REQ-018 On ack: output data register loads src_data[g]; dbus_oe=1 in the following cycle (one-cycle latency from ack to bus).
REQ-019 DRIVE with src_req[g]=0: stall; no ack, dbus_oe=0 next cycle, output data register holds, grant is retained.
REQ-020 ext_busy and requests from other sources are ignored in DRIVE, LAST and TURN.
REQ-021 Ack with src_last[g]=1: next state LAST; src_gnt clears at the same edge.
REQ-022 LAST: exactly one cycle; dbus_oe=1 with the final beat; next state TURN if TURN>0, else IDLE.
REQ-023 TURN: exactly TURN cycles with dbus_oe=0, counted by a down-counter loaded on entry; the cycle after it reaches zero, state=IDLE.
REQ-024 Consecutive bursts have at least TURN+2 dbus_oe=0 cycles between them: TURN cycles, the IDLE cycle and the first DRIVE cycle.
REQ-025 A single-beat burst (src_req and src_last both high in the first DRIVE cycle) is legal: DRIVE lasts 1 cycle, then LAST.
REQ-026 NSRC=1: round-robin degenerates to a fixed grant to source 0.
REQ-027 dbus_oe is never 1 in the cycle directly following a TURN or IDLE cycle, so two drivers are never enabled in adjacent cycles.

Reset
REQ-028 reset=1 asynchronously forces state=IDLE, dbus_oe=0 (dbus_data released to Z immediately), src_gnt=0, output data register=0, turnaround counter=0, prev_owner=NSRC-1 (source 0 wins first).
REQ-029 reset asserted mid-burst abandons the burst with no LAST cycle; after release, arbitration restarts in IDLE on the first clk edge.
REQ-030 src_ack is 0 throughout reset.

Verification
REQ-031 Reset, then src_req=4'b0001 with a 3-beat burst of data 0xA,0xB,0xC -> src_gnt=0001 on the cycle after the request; dbus_data shows 0xA,0xB,0xC on consecutive cycles starting one cycle after the first ack; then dbus_oe=0 for TURN=1 cycle.
REQ-032 src_req=4'b1111 held, every burst single-beat -> grants rotate in the order 0,1,2,3,0; each burst is separated by 3 dbus_oe=0 cycles.
REQ-033 ext_busy=1 for 5 cycles while src_req=0010 -> src_gnt stays 0 for those 5 cycles; grant appears the cycle after ext_busy falls.
REQ-034 Granted source drops src_req for 2 cycles mid-burst -> no ack on those cycles, dbus_oe=0 for 2 cycles, grant held, burst resumes with the next beat.
REQ-035 reset asserted while dbus_oe=1 mid-burst -> dbus_data goes to Z before the next clk edge, src_gnt=0; after release, src_req=1000 is granted within 1 cycle.
REQ-036 TURN=0 with WIDTH=8 and NSRC=2 -> LAST goes directly to IDLE; data width and one-hot grant are correct at these parameter values.

Source files
------------

// File: rtl/dbus_drive_ctl.sv
// dbus_drive_ctl: round-robin arbiter that hands a shared tri-state data bus to one
// source per burst, drives it from a registered data stage and inserts idle turnaround.
module dbus_drive_ctl #(
    parameter int WIDTH = 64,
    parameter int NSRC  = 4,
    parameter int TURN  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NSRC-1:0]       src_req,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC-1:0]       src_last,
    input  logic                  ext_busy,
    output logic [NSRC-1:0]       src_gnt,
    output logic [NSRC-1:0]       src_ack,
    output logic                  dbus_oe,
    output wire  [WIDTH-1:0]      dbus_data
);
    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [2:0] TURN_LOAD = (TURN > 0) ? 3'(TURN - 1) : 3'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_LAST,
        S_TURN
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IW-1:0]    prev_owner_q;
    logic [IW-1:0]    rr_cand;
    logic [IW-1:0]    rr_winner;
    logic             rr_found;
    logic [WIDTH-1:0] data_q;
    logic [2:0]       turn_cnt_q;
    logic [WIDTH-1:0] owner_data;
    logic             owner_last;
    logic             beat_ack;
    logic             start_burst;
    logic             end_burst;

    assign dbus_data = dbus_oe ? data_q : {WIDTH{1'bz}};

    // Search begins one past the previous owner so every requester gets a turn.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        rr_cand   = prev_owner_q;
        for (int k = 0; k < NSRC; k++) begin
            rr_cand = (rr_cand == IW'(NSRC - 1)) ? '0 : rr_cand + 1'b1;
            if (!rr_found && src_req[rr_cand]) begin
                rr_found  = 1'b1;
                rr_winner = rr_cand;
            end
        end
    end

    always_comb begin
        owner_data = '0;
        owner_last = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_gnt[i]) begin
                owner_data = src_data[i*WIDTH +: WIDTH];
                owner_last = src_last[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!ext_busy && rr_found) state_d = S_DRIVE;
            S_DRIVE: if (beat_ack && owner_last) state_d = S_LAST;
            S_LAST:  state_d = (TURN > 0) ? S_TURN : S_IDLE;
            S_TURN:  if (turn_cnt_q == 3'd0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        src_ack     = (state_q == S_DRIVE) ? (src_req & src_gnt) : '0;
        beat_ack    = |src_ack;
        start_burst = (state_q == S_IDLE) && !ext_busy && rr_found;
        end_burst   = beat_ack && owner_last;
    end

    // The grant drops on the same edge that captures the final beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_gnt      <= '0;
            dbus_oe      <= 1'b0;
            data_q       <= '0;
            turn_cnt_q   <= 3'd0;
            prev_owner_q <= IW'(NSRC - 1);
        end else begin
            dbus_oe <= beat_ack;
            if (beat_ack) begin
                data_q <= owner_data;
            end
            if (start_burst) begin
                src_gnt      <= NSRC'(1) << rr_winner;
                prev_owner_q <= rr_winner;
            end else if (end_burst) begin
                src_gnt <= '0;
            end
            if (state_q == S_LAST) begin
                turn_cnt_q <= TURN_LOAD;
            end else if (state_q == S_TURN && turn_cnt_q != 3'd0) begin
                turn_cnt_q <= turn_cnt_q - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_dbus_drive_ctl.sv
// tb_dbus_drive_ctl: directed scenarios plus a randomized run compared against a
// transaction-level model of bus ownership, cooldown and the one-cycle data pipeline.
module tb_dbus_drive_ctl;
    localparam int W = 64;
    localparam int N = 4;
    localparam int T = 1;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   src_req;
    logic [N*W-1:0] src_data;
    logic [N-1:0]   src_last;
    logic           ext_busy;
    logic [N-1:0]   src_gnt;
    logic [N-1:0]   src_ack;
    logic           dbus_oe;
    wire  [W-1:0]   dbus_data;

    logic [1:0]  req2;
    logic [15:0] data2;
    logic [1:0]  last2;
    logic        busy2;
    logic [1:0]  gnt2;
    logic [1:0]  ack2;
    logic        oe2;
    wire  [7:0]  dbus2;

    int n_checks = 0;
    int n_pass   = 0;

    dbus_drive_ctl #(.WIDTH(W), .NSRC(N), .TURN(T)) dut (
        .clk(clk), .reset(reset), .src_req(src_req), .src_data(src_data),
        .src_last(src_last), .ext_busy(ext_busy), .src_gnt(src_gnt),
        .src_ack(src_ack), .dbus_oe(dbus_oe), .dbus_data(dbus_data)
    );

    dbus_drive_ctl #(.WIDTH(8), .NSRC(2), .TURN(0)) dut2 (
        .clk(clk), .reset(reset), .src_req(req2), .src_data(data2),
        .src_last(last2), .ext_busy(busy2), .src_gnt(gnt2),
        .src_ack(ack2), .dbus_oe(oe2), .dbus_data(dbus2)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        src_req  = '0;
        src_data = '0;
        src_last = '0;
        ext_busy = 1'b0;
        req2     = '0;
        data2    = '0;
        last2    = '0;
        busy2    = 1'b0;
    endtask

    task automatic set_data(input int i, input logic [W-1:0] d);
        src_data[i*W +: W] = d;
    endtask

    // Leaves time one unit past a rising edge with reset released.
    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        #2 reset = 1'b1;
        src_req = 4'hF;
        req2    = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (src_gnt !== 4'b0000) $display("[TB] FAIL rst_gnt: got %b want 0000", src_gnt); else n_pass++;
        n_checks++; if (dbus_oe !== 1'b0) $display("[TB] FAIL rst_oe: got %b want 0", dbus_oe); else n_pass++;
        n_checks++; if (src_ack !== 4'b0000) $display("[TB] FAIL rst_ack: got %b want 0000", src_ack); else n_pass++;
        n_checks++; if (oe2 !== 1'b0 || gnt2 !== 2'b00) $display("[TB] FAIL rst_dut2: got oe=%b gnt=%b want 0/00", oe2, gnt2); else n_pass++;
        #1 reset = 1'b0;
    endtask

    task automatic test_single_burst();
        do_reset();
        src_req = 4'b0001;
        set_data(0, 64'hA);
        @(posedge clk); #1;
        n_checks++; if (src_gnt !== 4'b0001) $display("[TB] FAIL burst_gnt: got %b want 0001", src_gnt); else n_pass++;
        n_checks++; if (src_ack !== 4'b0001) $display("[TB] FAIL burst_ack: got %b want 0001", src_ack); else n_pass++;
        n_checks++; if (dbus_oe !== 1'b0) $display("[TB] FAIL burst_oe_first_drive: got %b want 0", dbus_oe); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (dbus_oe !== 1'b1 || dbus_data !== 64'hA) $display("[TB] FAIL burst_beat0: got oe=%b data=%h want 1/a", dbus_oe, dbus_data); else n_pass++;
        set_data(0, 64'hB);
        @(posedge clk); #1;
        n_checks++; if (dbus_oe !== 1'b1 || dbus_data !== 64'hB) $display("[TB] FAIL burst_beat1: got oe=%b data=%h want 1/b", dbus_oe, dbus_data); else n_pass++;
        set_data(0, 64'hC);
        src_last = 4'b0001;
        @(posedge clk); #1;
        n_checks++; if (dbus_oe !== 1'b1 || dbus_data !== 64'hC) $display("[TB] FAIL burst_beat2: got oe=%b data=%h want 1/c", dbus_oe, dbus_data); else n_pass++;
        n_checks++; if (src_gnt !== 4'b0000) $display("[TB] FAIL burst_gnt_clear: got %b want 0000", src_gnt); else n_pass++;
        src_req  = '0;
        src_last = '0;
        @(posedge clk); #1;
        n_checks++; if (dbus_oe !== 1'b0) $display("[TB] FAIL burst_turn_oe: got %b want 0", dbus_oe); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (dbus_oe !== 1'b0 || src_gnt !== 4'b0000) $display("[TB] FAIL burst_idle: got oe=%b gnt=%b want 0/0000", dbus_oe, src_gnt); else n_pass++;
    endtask

    task automatic test_rotation();
        int order[5];
        int gaps[4];
        int n_order = 0;
        int n_gaps  = 0;
        int run     = 0;
        bit seen_oe = 0;
        do_reset();
        src_req  = 4'hF;
        src_last = 4'hF;
        for (int i = 0; i < N; i++) set_data(i, {$urandom, $urandom});
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            if (src_gnt != '0 && n_order < 5) begin
                for (int b = 0; b < N; b++) if (src_gnt[b]) order[n_order] = b;
                n_order++;
            end
            if (dbus_oe) begin
                if (seen_oe && n_gaps < 4) begin
                    gaps[n_gaps] = run;
                    n_gaps++;
                end
                seen_oe = 1;
                run = 0;
            end else begin
                run++;
            end
        end
        src_req  = '0;
        src_last = '0;
        n_checks++; if (n_order != 5) $display("[TB] FAIL rot_count: got %0d grants want 5", n_order); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (order[k] != k % N) $display("[TB] FAIL rot_order%0d: got %0d want %0d", k, order[k], k % N); else n_pass++;
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (gaps[k] != T + 2) $display("[TB] FAIL rot_gap%0d: got %0d want %0d", k, gaps[k], T + 2); else n_pass++;
        end
    endtask

    task automatic test_ext_busy();
        do_reset();
        ext_busy = 1'b1;
        src_req  = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++; if (src_gnt !== 4'b0000) $display("[TB] FAIL busy_hold%0d: got %b want 0000", c, src_gnt); else n_pass++;
        end
        ext_busy = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (src_gnt !== 4'b0010) $display("[TB] FAIL busy_release_gnt: got %b want 0010", src_gnt); else n_pass++;
        n_checks++; if (src_ack !== 4'b0010) $display("[TB] FAIL busy_release_ack: got %b want 0010", src_ack); else n_pass++;
        src_req = '0;
    endtask

    task automatic test_stall();
        do_reset();
        src_req = 4'b0100;
        set_data(2, 64'h1111);
        @(posedge clk); #1;
        n_checks++; if (src_gnt !== 4'b0100) $display("[TB] FAIL stall_gnt: got %b want 0100", src_gnt); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (dbus_oe !== 1'b1 || dbus_data !== 64'h1111) $display("[TB] FAIL stall_beat0: got oe=%b data=%h want 1/1111", dbus_oe, dbus_data); else n_pass++;
        src_req = 4'b0000;
        set_data(2, 64'hDEAD);
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (src_ack !== 4'b0000) $display("[TB] FAIL stall_ack%0d: got %b want 0000", c, src_ack); else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (dbus_oe !== 1'b0 || src_gnt !== 4'b0100) $display("[TB] FAIL stall_hold%0d: got oe=%b gnt=%b want 0/0100", c, dbus_oe, src_gnt); else n_pass++;
        end
        src_req  = 4'b0100;
        src_last = 4'b0100;
        set_data(2, 64'h2222);
        #1;
        n_checks++; if (src_ack !== 4'b0100) $display("[TB] FAIL stall_resume_ack: got %b want 0100", src_ack); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (dbus_oe !== 1'b1 || dbus_data !== 64'h2222) $display("[TB] FAIL stall_resume_beat: got oe=%b data=%h want 1/2222", dbus_oe, dbus_data); else n_pass++;
        src_req  = '0;
        src_last = '0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        src_req = 4'b0100;
        set_data(2, 64'h5555);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (dbus_oe !== 1'b1) $display("[TB] FAIL midrst_pre_oe: got %b want 1", dbus_oe); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (dbus_oe !== 1'b0) $display("[TB] FAIL midrst_oe: got %b want 0", dbus_oe); else n_pass++;
        n_checks++; if (src_gnt !== 4'b0000) $display("[TB] FAIL midrst_gnt: got %b want 0000", src_gnt); else n_pass++;
        n_checks++; if (src_ack !== 4'b0000) $display("[TB] FAIL midrst_ack: got %b want 0000", src_ack); else n_pass++;
        src_req = 4'b1000;
        #2 reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (src_gnt !== 4'b1000) $display("[TB] FAIL midrst_regrant: got %b want 1000", src_gnt); else n_pass++;
        src_req = '0;
    endtask

    task automatic test_turn0();
        do_reset();
        req2  = 2'b10;
        last2 = 2'b10;
        data2 = 16'h5A00;
        @(posedge clk); #1;
        n_checks++; if (gnt2 !== 2'b10 || ack2 !== 2'b10) $display("[TB] FAIL t0_gnt: got gnt=%b ack=%b want 10/10", gnt2, ack2); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (oe2 !== 1'b1 || dbus2 !== 8'h5A) $display("[TB] FAIL t0_last: got oe=%b data=%h want 1/5a", oe2, dbus2); else n_pass++;
        n_checks++; if (gnt2 !== 2'b00) $display("[TB] FAIL t0_gnt_clear: got %b want 00", gnt2); else n_pass++;
        data2 = 16'hC300;
        @(posedge clk); #1;
        n_checks++; if (oe2 !== 1'b0 || gnt2 !== 2'b00) $display("[TB] FAIL t0_idle: got oe=%b gnt=%b want 0/00", oe2, gnt2); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (gnt2 !== 2'b10 || oe2 !== 1'b0) $display("[TB] FAIL t0_regrant: got gnt=%b oe=%b want 10/0", gnt2, oe2); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (oe2 !== 1'b1 || dbus2 !== 8'hC3) $display("[TB] FAIL t0_second: got oe=%b data=%h want 1/c3", oe2, dbus2); else n_pass++;
        req2  = '0;
        last2 = '0;
    endtask

    // Model: an owner holds the bus until its last beat, then arbitration is
    // suppressed for the LAST cycle plus T turnaround cycles.
    task automatic test_random(input int ncyc);
        int           owner = -1;
        int           cool  = 0;
        int           prev  = N - 1;
        logic         exp_oe = 1'b0;
        logic [W-1:0] exp_data = '0;
        logic [N-1:0] exp_gnt;
        logic [N-1:0] exp_ack;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            ext_busy = ($urandom_range(0, 3) == 0);
            src_req  = N'($urandom);
            src_last = '0;
            for (int i = 0; i < N; i++) begin
                set_data(i, {$urandom, $urandom});
                src_last[i] = ($urandom_range(0, 2) == 0);
            end
            #1;
            exp_ack = (owner >= 0) ? (src_req & (N'(1) << owner)) : '0;
            n_checks++; if (src_ack !== exp_ack) $display("[TB] FAIL rnd_ack c%0d: got %b want %b", c, src_ack, exp_ack); else n_pass++;
            if (owner >= 0) begin
                if (((src_req >> owner) & 1) != 0) begin
                    exp_oe   = 1'b1;
                    exp_data = W'(src_data >> (owner * W));
                    if (((src_last >> owner) & 1) != 0) begin
                        owner = -1;
                        cool  = 1 + T;
                    end
                end else begin
                    exp_oe = 1'b0;
                end
            end else if (cool > 0) begin
                cool--;
                exp_oe = 1'b0;
            end else begin
                exp_oe = 1'b0;
                if (!ext_busy) begin
                    for (int k = 1; k <= N; k++) begin
                        if (owner < 0 && ((src_req >> ((prev + k) % N)) & 1) != 0) owner = (prev + k) % N;
                    end
                    if (owner >= 0) prev = owner;
                end
            end
            @(posedge clk); #1;
            exp_gnt = (owner >= 0) ? (N'(1) << owner) : '0;
            n_checks++; if (src_gnt !== exp_gnt) $display("[TB] FAIL rnd_gnt c%0d: got %b want %b", c, src_gnt, exp_gnt); else n_pass++;
            n_checks++; if (dbus_oe !== exp_oe) $display("[TB] FAIL rnd_oe c%0d: got %b want %b", c, dbus_oe, exp_oe); else n_pass++;
            if (exp_oe) begin
                n_checks++; if (dbus_data !== exp_data) $display("[TB] FAIL rnd_data c%0d: got %h want %h", c, dbus_data, exp_data); else n_pass++;
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_burst();
        test_rotation();
        test_ext_busy();
        test_stall();
        test_reset_mid_burst();
        test_turn0();
        test_random(400);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
